// File: rtl/edge_event_capture.sv
// edge_event_capture: multi-channel synchroniser, glitch filter and edge/event
// capture with sticky pending flags, saturating counters and combined irq.
//
// Ports:
//   smpl_clk   sample clock, all state on its rising edge
//   rst        synchronous active-high reset (acts regardless of CE)
//   CE         sample enable for sync chain, filter and edge logic
//   async_sig  NCH asynchronous inputs, bit i = channel i
//   mode       per-channel event select [2i+1:2i]: 00 none 01 rise 10 fall 11 both
//   clr        per-channel clear of event_pend[i] and its counter
//   level      filtered, synchronised level
//   rise/fall  one-cycle pulses on accepted level transitions
//   event_pend sticky flag set on a mode-qualified edge
//   event_cnt  saturating counters, channel i at [CNT_W*i +: CNT_W]
//   irq        OR of all event_pend bits
module edge_event_capture #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int CNT_W       = 16
) (
    input  logic                 smpl_clk,
    input  logic                 rst,
    input  logic                 CE,
    input  logic [NCH-1:0]       async_sig,
    input  logic [2*NCH-1:0]     mode,
    input  logic [NCH-1:0]       clr,
    output logic [NCH-1:0]       level,
    output logic [NCH-1:0]       rise,
    output logic [NCH-1:0]       fall,
    output logic [NCH-1:0]       event_pend,
    output logic [NCH*CNT_W-1:0] event_cnt,
    output logic                 irq
);

    localparam int FCW_RAW = $clog2(FILT_LEN + 1);
    localparam int FCW     = (FCW_RAW < 1) ? 1 : FCW_RAW;

    localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q [NCH];
    logic [SYNC_STAGES-1:0] sync_d [NCH];
    logic [FCW-1:0]         filt_q [NCH];
    logic [FCW-1:0]         filt_d [NCH];
    logic [CNT_W-1:0]       cnt_q  [NCH];
    logic [CNT_W-1:0]       cnt_d  [NCH];

    logic [NCH-1:0] level_q, level_d;
    logic [NCH-1:0] rise_q, rise_d;
    logic [NCH-1:0] fall_q, fall_d;
    logic [NCH-1:0] pend_q, pend_d;

    // Resynchronised sample seen by the filter (last sync stage).
    logic [NCH-1:0] s;
    logic [NCH-1:0] accept;
    logic [NCH-1:0] qual;

    // Resynchroniser: bit 0 takes the raw input, the top bit feeds the filter.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sync_d[i] = sync_q[i];
            if (CE) begin
                sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], async_sig[i]};
            end
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Glitch filter, edge pulses and event bookkeeping.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            filt_d[i]  = filt_q[i];
            level_d[i] = level_q[i];
            accept[i]  = 1'b0;
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            qual[i]    = 1'b0;
            pend_d[i]  = pend_q[i];
            cnt_d[i]   = cnt_q[i];

            if (CE) begin
                if (s[i] == level_q[i]) begin
                    filt_d[i] = '0;
                end else if (filt_q[i] == FILT_LAST) begin
                    // FILT_LEN-th consecutive differing sample.
                    level_d[i] = s[i];
                    filt_d[i]  = '0;
                    accept[i]  = 1'b1;
                end else begin
                    filt_d[i] = filt_q[i] + FCW'(1);
                end
            end

            rise_d[i] = accept[i] & s[i];
            fall_d[i] = accept[i] & ~s[i];
            qual[i]   = (rise_d[i] & mode[2*i]) |
                        (fall_d[i] & mode[2*i+1]);

            // A same-edge event beats clr: the cleared counter restarts at 1.
            if (qual[i]) begin
                pend_d[i] = 1'b1;
                if (clr[i]) begin
                    cnt_d[i] = CNT_ONE;
                end else if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (clr[i]) begin
                pend_d[i] = 1'b0;
                cnt_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge smpl_clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= '0;
                filt_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= sync_d[i];
                filt_q[i] <= filt_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        event_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            event_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign event_pend = pend_q;
    assign irq        = |pend_q;

endmodule

// File: tb/tb_edge_event_capture.sv
// Self-checking bench for edge_event_capture: vector table, directed
// corner-case sequences and randomized stimulus against a reference model.
module tb_edge_event_capture;

    localparam int NCH   = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [3:0]  sig = '0;
    logic [7:0]  mode = 8'hFF;
    logic [3:0]  clr = '0;
    logic [3:0]  level, rise, fall, event_pend;
    logic [15:0] event_cnt;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    int rise_seen [NCH];
    int fall_seen [NCH];

    edge_event_capture #(
        .NCH(NCH), .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .CNT_W(CNT_W)
    ) dut (
        .smpl_clk(clk), .rst(rst), .CE(ce), .async_sig(sig),
        .mode(mode), .clr(clr), .level(level), .rise(rise), .fall(fall),
        .event_pend(event_pend), .event_cnt(event_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples taken on CE edges travel through a
    // SYNC-deep delay line; the level flips once the last FILT samples
    // seen by the filter all differ from it.
    bit samp [NCH][$];
    bit fh   [NCH][$];
    bit m_level [NCH];
    bit m_rise  [NCH];
    bit m_fall  [NCH];
    bit m_pend  [NCH];
    int m_cnt   [NCH];

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            samp[c].delete();
            fh[c].delete();
            repeat (SYNC) samp[c].push_back(1'b0);
            repeat (FILT) fh[c].push_back(1'b0);
            m_level[c] = 0;
            m_rise[c]  = 0;
            m_fall[c]  = 0;
            m_pend[c]  = 0;
            m_cnt[c]   = 0;
        end
    endfunction

    function automatic void model_step();
        bit s;
        bit all_diff;
        bit q;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            m_rise[c] = 0;
            m_fall[c] = 0;
            if (ce) begin
                s = samp[c].pop_front();
                samp[c].push_back(sig[c]);
                fh[c].push_back(s);
                fh[c].delete(0);
                all_diff = 1;
                foreach (fh[c][k]) if (fh[c][k] == m_level[c]) all_diff = 0;
                if (all_diff) begin
                    m_level[c] = s;
                    m_rise[c]  = s;
                    m_fall[c]  = !s;
                end
            end
            q = (m_rise[c] && mode[2*c]) || (m_fall[c] && mode[2*c+1]);
            if (q) begin
                m_pend[c] = 1;
                if (clr[c]) m_cnt[c] = 1;
                else if (m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
            end else if (clr[c]) begin
                m_pend[c] = 0;
                m_cnt[c]  = 0;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        logic [3:0]  el, er, ef, ep;
        logic [15:0] ec;
        logic        ei;
        ei = 0;
        for (int c = 0; c < NCH; c++) begin
            el[c] = m_level[c];
            er[c] = m_rise[c];
            ef[c] = m_fall[c];
            ep[c] = m_pend[c];
            ec[4*c +: 4] = 4'(m_cnt[c]);
            ei = ei | m_pend[c];
        end
        chk("model.level", 64'(level), 64'(el));
        chk("model.rise", 64'(rise), 64'(er));
        chk("model.fall", 64'(fall), 64'(ef));
        chk("model.pend", 64'(event_pend), 64'(ep));
        chk("model.cnt", 64'(event_cnt), 64'(ec));
        chk("model.irq", 64'(irq), 64'(ei));
    endtask

    task automatic apply(input logic r, input logic e, input logic [3:0] s,
                         input logic [7:0] m, input logic [3:0] c);
        rst  = r;
        ce   = e;
        sig  = s;
        mode = m;
        clr  = c;
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
        for (int k = 0; k < NCH; k++) begin
            if (rise[k] === 1'b1) rise_seen[k]++;
            if (fall[k] === 1'b1) fall_seen[k]++;
        end
    endtask

    task automatic clear_seen();
        for (int k = 0; k < NCH; k++) begin
            rise_seen[k] = 0;
            fall_seen[k] = 0;
        end
    endtask

    task automatic pulse(input int ch, input logic [7:0] m, input int hi,
                         input int lo);
        logic [3:0] b;
        b = 4'(1 << ch);
        repeat (hi) apply(0, 1, b, m, 4'h0);
        repeat (lo) apply(0, 1, 4'h0, m, 4'h0);
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [3:0] s;
        logic [3:0] c;
        logic [3:0] lv;
        logic [3:0] ri;
        logic [3:0] fa;
        logic [3:0] pd;
        logic       iq;
        logic [3:0] c0;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [3:0] hold [NCH];
        logic [3:0] ns;
        logic [3:0] nc;
        logic [7:0] nm;

        clear_seen();
        model_reset();

        // Latency with CE=1 (rise), clr, then latency with CE toggling (fall).
        tbl[0]  = '{1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[1]  = '{0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[2]  = '{0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[3]  = '{0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[4]  = '{0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[5]  = '{0, 1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1, 4'h1};
        tbl[6]  = '{0, 1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1, 4'h1};
        tbl[7]  = '{0, 1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[8]  = '{0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[9]  = '{0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[10] = '{0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[11] = '{0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[12] = '{0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[13] = '{0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[14] = '{0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[15] = '{0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0};
        tbl[16] = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 1, 4'h1};
        tbl[17] = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1, 4'h1};

        #2;
        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].s, 8'hFF, tbl[i].c);
            chk($sformatf("v%0d.level", i), 64'(level), 64'(tbl[i].lv));
            chk($sformatf("v%0d.rise", i), 64'(rise), 64'(tbl[i].ri));
            chk($sformatf("v%0d.fall", i), 64'(fall), 64'(tbl[i].fa));
            chk($sformatf("v%0d.pend", i), 64'(event_pend), 64'(tbl[i].pd));
            chk($sformatf("v%0d.irq", i), 64'(irq), 64'(tbl[i].iq));
            chk($sformatf("v%0d.cnt0", i), 64'(event_cnt[3:0]),
                64'(tbl[i].c0));
        end

        // Glitch: 2 samples suppressed, 3 samples accepted both ways.
        apply(1, 0, 4'h0, 8'hFF, 4'h0);
        clear_seen();
        pulse(1, 8'hFF, 2, 8);
        chk("glitch2.rise", 64'(rise_seen[1]), 64'd0);
        chk("glitch2.cnt", 64'(event_cnt[7:4]), 64'd0);
        chk("glitch2.level", 64'(level[1]), 64'd0);
        clear_seen();
        pulse(1, 8'hFF, 3, 7);
        chk("glitch3.rise", 64'(rise_seen[1]), 64'd1);
        chk("glitch3.fall", 64'(fall_seen[1]), 64'd1);
        chk("glitch3.cnt", 64'(event_cnt[7:4]), 64'd2);

        // Mode selection on ch2.
        apply(1, 0, 4'h0, 8'hFF, 4'h0);
        clear_seen();
        repeat (3) pulse(2, 8'hDF, 6, 6);
        chk("mode01.rise", 64'(rise_seen[2]), 64'd3);
        chk("mode01.fall", 64'(fall_seen[2]), 64'd3);
        chk("mode01.cnt", 64'(event_cnt[11:8]), 64'd3);
        pulse(2, 8'hEF, 6, 6);
        chk("mode10.cnt", 64'(event_cnt[11:8]), 64'd4);
        pulse(2, 8'hCF, 6, 6);
        chk("mode00.cnt", 64'(event_cnt[11:8]), 64'd4);
        chk("mode00.pend", 64'(event_pend[2]), 64'd1);

        // Saturation and clear on ch3.
        apply(1, 0, 4'h0, 8'hFF, 4'h0);
        repeat (10) pulse(3, 8'hFF, 5, 5);
        chk("sat.cnt", 64'(event_cnt[15:12]), 64'd15);
        apply(0, 1, 4'h0, 8'hFF, 4'h8);
        chk("clr.cnt", 64'(event_cnt[15:12]), 64'd0);
        chk("clr.pend", 64'(event_pend[3]), 64'd0);
        chk("clr.irq", 64'(irq), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            apply(0, 1, 4'h8, 8'hFF, (k == 5) ? 4'h8 : 4'h0);
        end
        chk("clrwin.cnt", 64'(event_cnt[15:12]), 64'd1);
        chk("clrwin.pend", 64'(event_pend[3]), 64'd1);

        // Reset mid-filter with CE=0, ch0 held high through release.
        repeat (4) apply(0, 1, 4'h9, 8'hFF, 4'h0);
        apply(1, 0, 4'h9, 8'hFF, 4'h0);
        chk("rst.level", 64'(level), 64'd0);
        chk("rst.pend", 64'(event_pend), 64'd0);
        chk("rst.cnt", 64'(event_cnt), 64'd0);
        chk("rst.irq", 64'(irq), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            apply(0, 1, 4'h9, 8'hFF, 4'h0);
            chk($sformatf("rstrel%0d.rise", k), 64'(rise),
                (k == 5) ? 64'h9 : 64'h0);
        end

        // Simultaneous rise on every channel.
        apply(1, 0, 4'h0, 8'hFF, 4'h0);
        repeat (5) apply(0, 1, 4'hF, 8'hFF, 4'h0);
        chk("simul.rise", 64'(rise), 64'hF);
        chk("simul.cnt", 64'(event_cnt), 64'h1111);
        apply(0, 1, 4'hF, 8'hFF, 4'h0);
        chk("simul.rise_end", 64'(rise), 64'h0);

        // Randomized run against the model.
        apply(1, 0, 4'h0, 8'hFF, 4'h0);
        ns = '0;
        nm = 8'hFF;
        for (int c = 0; c < NCH; c++) hold[c] = 4'($urandom_range(1, 6));
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    ns[c]   = ~ns[c];
                    hold[c] = 4'($urandom_range(1, 6));
                end else begin
                    hold[c] = hold[c] - 4'd1;
                end
            end
            if ($urandom_range(0, 49) == 0) nm = 8'($urandom);
            nc = '0;
            for (int c = 0; c < NCH; c++) begin
                nc[c] = ($urandom_range(0, 39) == 0);
            end
            apply(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0),
                  ns, nm, nc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
